// File: rtl/seq_det_ctrl.sv
// Word-serial 1011 detector: accept, DATA_W shift cycles, one DONE cycle; in_ready only while IDLE.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; default restarts the detector from S0 after a hit.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              hit,
  output logic              byte_done,
  output logic [CNT_W-1:0]  match_cnt
);
  localparam int BC_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_t;

  state_t            state;
  det_t              det;
  det_t              det_nxt;
  logic              det_hit;
  logic [DATA_W-1:0] sreg;
  logic [BC_W-1:0]   bcnt;
  logic              cur_bit;

  assign cur_bit = sreg[DATA_W-1];

  always_comb begin
    det_nxt = det;
    det_hit = 1'b0;
    case (det)
      S0:   det_nxt = cur_bit ? S1 : S0;
      S1:   det_nxt = cur_bit ? S1 : S10;
      S10:  det_nxt = cur_bit ? S101 : S0;
      S101: begin
        if (cur_bit) begin
          det_hit = 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
          det_nxt = S1;
`else
          det_nxt = S0;
`endif
        end else begin
          det_nxt = S10;
        end
      end
      default: det_nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      det       <= S0;
      sreg      <= '0;
      bcnt      <= '0;
      match_cnt <= '0;
      hit       <= 1'b0;
      byte_done <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      hit       <= 1'b0;
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            bcnt     <= BC_W'(DATA_W - 1);
            state    <= SHIFT;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          // detector only advances here, so a pattern may straddle words
          det  <= det_nxt;
          hit  <= det_hit;
          sreg <= {sreg[DATA_W-2:0], 1'b0};
          bcnt <= bcnt - 1'b1;
          if (bcnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            byte_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase

      if (clr_cnt)
        match_cnt <= '0;
      else if (state == SHIFT && det_hit && match_cnt != {CNT_W{1'b1}})
        match_cnt <= match_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random traffic, checked every cycle against a suffix-matching model.
module tb_seq_det_ctrl;
  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          clr_cnt;
  logic          busy;
  logic          hit;
  logic          byte_done;
  logic [CW-1:0] match_cnt;

  seq_det_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clr_cnt   (clr_cnt),
    .busy      (busy),
    .hit       (hit),
    .byte_done (byte_done),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word timing from the accept edge index, detection by matching the
  // last four scanned bits against 1011 within the current detection window.
  int            e = 0;
  int            t_acc = 0;
  bit            act_m = 0;
  bit            mdl_ok = 0;
  logic [DW-1:0] word_m = '0;
  logic [3:0]    hist = '0;
  int            nb = 0;
  int            cnt_e = 0;
  bit            hit_e = 0;
  bit            bd_e = 0;
  bit            busy_e = 0;
  bit            rdy_e = 1;

  always @(posedge clk) begin : model
    int k;
    e++;
    if (rst) begin
      act_m = 0; hist = '0; nb = 0; cnt_e = 0; hit_e = 0; bd_e = 0; mdl_ok = 1;
    end else begin
      hit_e = 0;
      bd_e  = 0;
      if (act_m) begin
        k = e - t_acc;
        if (k <= DW) begin
          hist = {hist[2:0], word_m[DW-k]};
          nb++;
          if (hist == 4'b1011 && nb >= 4) begin
            hit_e = 1;
`ifndef SEQ_DET_OVERLAP_EN
            nb = 0;
`endif
          end
          if (k == DW) bd_e = 1;
        end else begin
          act_m = 0;
        end
      end else if (in_valid) begin
        act_m  = 1;
        t_acc  = e;
        word_m = in_data;
      end
      if (clr_cnt) cnt_e = 0;
      else if (hit_e && cnt_e < CMAX) cnt_e++;
    end
    busy_e = act_m && ((e - t_acc) < DW);
    rdy_e  = !act_m;
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("in_ready", 32'(in_ready), 32'(rdy_e));
      chk("busy", 32'(busy), 32'(busy_e));
      chk("hit", 32'(hit), 32'(hit_e));
      chk("byte_done", 32'(byte_done), 32'(bd_e));
      chk("match_cnt", 32'(match_cnt), 32'(cnt_e));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int hit_ks[$];
  int bd_k;
  int cnt_at_clr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int hk(input int i);
    return (i < hit_ks.size()) ? hit_ks[i] : -1;
  endfunction

  // Offers one word, then records the shift index (1..DW) after which hit / byte_done were seen.
  task automatic run_word(input logic [DW-1:0] w, input int clr_k);
    int guard;
    guard = 0;
    hit_ks.delete();
    bd_k = -1;
    cnt_at_clr = -1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_wait", 32'(guard < 50), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    for (int k = 1; k <= DW + 1; k++) begin
      clr_cnt = (k == clr_k);
      step();
      clr_cnt = 1'b0;
      if (hit) hit_ks.push_back(k);
      if (byte_done) bd_k = k;
      if (k == clr_k) cnt_at_clr = int'(match_cnt);
    end
  endtask

  initial begin
    int rdy_hi;
    int bd_cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
    step();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_byte_done", 32'(byte_done), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);

    // 0xB0: single hit after shift 4
    run_word(8'hB0, 0);
    chk("b0_hits", hit_ks.size(), 1);
    chk("b0_hit_at", hk(0), 4);
    chk("b0_done_at", bd_k, 8);
    chk("b0_cnt", 32'(match_cnt), 32'd1);

    // 0xB6: overlap-dependent
    do_reset();
    run_word(8'hB6, 0);
`ifdef SEQ_DET_OVERLAP_EN
    chk("b6_hits", hit_ks.size(), 2);
    chk("b6_hit2_at", hk(1), 7);
    chk("b6_cnt", 32'(match_cnt), 32'd2);
`else
    chk("b6_hits", hit_ks.size(), 1);
    chk("b6_cnt", 32'(match_cnt), 32'd1);
`endif
    chk("b6_hit1_at", hk(0), 4);

    // 0x01 then 0x60 back-to-back: pattern straddles words
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_data  = 8'h60;
    hit_ks.delete();
    rdy_hi = 0;
    for (int j = 1; j <= 19; j++) begin
      step();
      if (j == 10) in_valid = 1'b0;
      if (hit) hit_ks.push_back(j);
      if (in_ready && j <= 18) rdy_hi++;
    end
    chk("span_hits", hit_ks.size(), 1);
    chk("span_hit_at", hk(0), 13);
    chk("span_ready_cycles", rdy_hi, 1);
    chk("span_cnt", 32'(match_cnt), 32'd1);

    // saturation with 0xBB, then clear on a hit edge
    do_reset();
    for (int i = 0; i < 8; i++) run_word(8'hBB, 0);
    chk("sat_cnt", 32'(match_cnt), 32'd15);
    run_word(8'hBB, 4);
    chk("clr_hit_at4", 32'(hk(0) == 4), 32'd1);
    chk("clr_cnt_on_hit", cnt_at_clr, 0);
    chk("clr_cnt_after", 32'(match_cnt), 32'd1);

    // reset at shift edge 3 of 0xFF
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_byte_done", 32'(byte_done), 32'd0);
    bd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (byte_done || hit) bd_cnt++;
    end
    chk("abort_no_pulses", bd_cnt, 0);
    run_word(8'hB0, 0);
    chk("abort_b0_hit_at", hk(0), 4);
    chk("abort_b0_cnt", 32'(match_cnt), 32'd1);

    // in_valid held with changing data during SHIFT
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'hB0;
    step();
    hit_ks.delete();
    bd_k = -1;
    for (int k = 1; k <= DW + 1; k++) begin
      in_data = DW'($urandom);
      step();
      if (hit) hit_ks.push_back(k);
      if (byte_done) bd_k = k;
    end
    chk("hold_hits", hit_ks.size(), 1);
    chk("hold_hit_at", hk(0), 4);
    chk("hold_done_at", bd_k, 8);
    chk("hold_ready_idle", 32'(in_ready), 32'd1);
    step();
    chk("hold_accept_next", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // random traffic, model checked every cycle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = DW'($urandom);
      clr_cnt  = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
